// File: rtl/cpu_issue_scoreboard.sv
// Issue-stage hazard controller: load scoreboard, multiplier busy countdown,
// drain interlock for CP0/exception instructions and a saturating stall counter.
module cpu_issue_scoreboard #(
    parameter int MUL_LAT   = 4,
    parameter int MAX_LOADS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [4:0]  dec_reg_read_1,
    input  logic [4:0]  dec_reg_read_2,
    input  logic [4:0]  dec_reg_write,
    input  logic        dec_is_load,
    input  logic        dec_is_mulexec,
    input  logic        dec_is_mulmove,
    input  logic        dec_is_nop,
    input  logic        dec_is_drain,
    input  logic        flush,
    input  logic        load_done,
    input  logic [4:0]  load_done_reg,
    output logic        issue,
    output logic        stall,
    output logic [31:0] pending,
    output logic        mul_busy,
    output logic [3:0]  load_count,
    output logic [31:0] stall_cycles
);

    localparam logic [3:0] MUL_LAT_C   = 4'(MUL_LAT);
    localparam logic [3:0] MAX_LOADS_C = 4'(MAX_LOADS);

    logic [31:0] pending_q, pending_d;
    logic [3:0]  load_count_q, load_count_d;
    logic [3:0]  mul_cnt_q, mul_cnt_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    logic raw, waw, mul_hz, ld_full, drain_hz, hold;
    logic active, ld_inc, ld_dec;

    // Hazards look only at registered state; a completing load frees its
    // consumer one cycle later, which keeps the issue path short.
    always_comb begin
        raw = ((dec_reg_read_1 != 5'd0) && pending_q[dec_reg_read_1]) ||
              ((dec_reg_read_2 != 5'd0) && pending_q[dec_reg_read_2]);
        waw      = (dec_reg_write != 5'd0) && pending_q[dec_reg_write];
        mul_hz   = (dec_is_mulexec || dec_is_mulmove) && (mul_cnt_q != 4'd0);
        ld_full  = dec_is_load && (load_count_q == MAX_LOADS_C);
        drain_hz = dec_is_drain &&
                   ((load_count_q != 4'd0) || (mul_cnt_q != 4'd0));
        hold     = (raw || waw || mul_hz || ld_full || drain_hz) && !dec_is_nop;
        active   = dec_valid && !flush && !rst;
        issue    = active && !hold;
        stall    = active && hold;
    end

    always_comb begin
        ld_inc = issue && dec_is_load;
        ld_dec = load_done && (load_count_q != 4'd0);

        pending_d = pending_q;
        if (load_done && (load_done_reg != 5'd0))
            pending_d[load_done_reg] = 1'b0;
        if (ld_inc && (dec_reg_write != 5'd0))
            pending_d[dec_reg_write] = 1'b1;
        pending_d[0] = 1'b0;

        load_count_d = load_count_q;
        if (ld_inc && !ld_dec)
            load_count_d = load_count_q + 4'd1;
        else if (!ld_inc && ld_dec)
            load_count_d = load_count_q - 4'd1;

        mul_cnt_d = mul_cnt_q;
        if (issue && dec_is_mulexec)
            mul_cnt_d = MUL_LAT_C;
        else if (mul_cnt_q != 4'd0)
            mul_cnt_d = mul_cnt_q - 4'd1;

        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF))
            stall_cycles_d = stall_cycles_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q      <= 32'd0;
            load_count_q   <= 4'd0;
            mul_cnt_q      <= 4'd0;
            stall_cycles_q <= 32'd0;
        end else begin
            pending_q      <= pending_d;
            load_count_q   <= load_count_d;
            mul_cnt_q      <= mul_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign pending      = pending_q;
    assign load_count   = load_count_q;
    assign mul_busy     = (mul_cnt_q != 4'd0);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_cpu_issue_scoreboard.sv
// Directed bench for cpu_issue_scoreboard: expectations queued per step,
// popped and asserted when the cycle's outputs are sampled.
module tb_cpu_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [4:0]  dec_reg_read_1, dec_reg_read_2, dec_reg_write;
    logic        dec_is_load, dec_is_mulexec, dec_is_mulmove;
    logic        dec_is_nop, dec_is_drain, flush;
    logic        load_done;
    logic [4:0]  load_done_reg;
    logic        issue, stall, mul_busy;
    logic [31:0] pending, stall_cycles;
    logic [3:0]  load_count;

    cpu_issue_scoreboard #(.MUL_LAT(4), .MAX_LOADS(4)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid),
        .dec_reg_read_1(dec_reg_read_1), .dec_reg_read_2(dec_reg_read_2),
        .dec_reg_write(dec_reg_write), .dec_is_load(dec_is_load),
        .dec_is_mulexec(dec_is_mulexec), .dec_is_mulmove(dec_is_mulmove),
        .dec_is_nop(dec_is_nop), .dec_is_drain(dec_is_drain),
        .flush(flush), .load_done(load_done), .load_done_reg(load_done_reg),
        .issue(issue), .stall(stall), .pending(pending),
        .mul_busy(mul_busy), .load_count(load_count),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] sc_exp   = 32'd0;

    task automatic push(input string t, input logic [31:0] v);
        exp_t e;
        e.tag = t;
        e.exp = v;
        q.push_back(e);
    endtask

    function automatic logic [31:0] obs(input string t);
        logic [31:0] r;
        r = 32'hDEAD_BEEF;
        case (t)
            "issue":        r = {31'd0, issue};
            "stall":        r = {31'd0, stall};
            "pending":      r = pending;
            "mul_busy":     r = {31'd0, mul_busy};
            "load_count":   r = {28'd0, load_count};
            "stall_cycles": r = stall_cycles;
            default:        r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    task automatic drain_check();
        exp_t        e;
        logic [31:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.tag);
            n_assert++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic idle();
        dec_valid      = 1'b0;
        dec_reg_read_1 = 5'd0;
        dec_reg_read_2 = 5'd0;
        dec_reg_write  = 5'd0;
        dec_is_load    = 1'b0;
        dec_is_mulexec = 1'b0;
        dec_is_mulmove = 1'b0;
        dec_is_nop     = 1'b0;
        dec_is_drain   = 1'b0;
        flush          = 1'b0;
        load_done      = 1'b0;
        load_done_reg  = 5'd0;
    endtask

    // One cycle: queue issue/stall, sample at negedge, then advance.
    task automatic chk(input logic ei, input logic es);
        push("issue", {31'd0, ei});
        push("stall", {31'd0, es});
        @(negedge clk);
        drain_check();
        if (es)
            sc_exp = sc_exp + 32'd1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        dec_valid = 1'b1;
        push("pending", 32'd0);
        push("load_count", 32'd0);
        push("mul_busy", 32'd0);
        push("stall_cycles", 32'd0);
        chk(1'b0, 1'b0);
        rst = 1'b0;

        // load $5, dependent add stalls until the cycle after load_done
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd5;
        chk(1'b1, 1'b0);
        idle(); dec_valid = 1'b1; dec_reg_read_1 = 5'd5; dec_reg_write = 5'd6;
        push("pending", 32'h20);
        push("load_count", 32'd1);
        chk(1'b0, 1'b1);
        load_done = 1'b1; load_done_reg = 5'd5;
        push("stall_cycles", sc_exp);
        chk(1'b0, 1'b1);
        load_done = 1'b0;
        push("pending", 32'd0);
        push("load_count", 32'd0);
        chk(1'b1, 1'b0);

        // mulexec then mfhi: stalled for MUL_LAT cycles
        idle(); dec_valid = 1'b1; dec_is_mulexec = 1'b1;
        chk(1'b1, 1'b0);
        idle(); dec_valid = 1'b1; dec_is_mulmove = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push("mul_busy", 32'd1);
            chk(1'b0, 1'b1);
        end
        push("mul_busy", 32'd0);
        chk(1'b1, 1'b0);

        // five independent loads against MAX_LOADS = 4
        for (int i = 0; i < 4; i++) begin
            idle(); dec_valid = 1'b1; dec_is_load = 1'b1;
            dec_reg_write = 5'(i + 1);
            push("load_count", 32'(i));
            chk(1'b1, 1'b0);
        end
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd8;
        push("load_count", 32'd4);
        chk(1'b0, 1'b1);
        load_done = 1'b1; load_done_reg = 5'd1;
        chk(1'b0, 1'b1);
        load_done = 1'b0;
        push("load_count", 32'd3);
        chk(1'b1, 1'b0);
        idle();
        push("load_count", 32'd4);
        push("pending", 32'h0000_011C);
        chk(1'b0, 1'b0);

        // drain instruction waits for every outstanding load
        idle(); dec_valid = 1'b1; dec_is_drain = 1'b1;
        chk(1'b0, 1'b1);
        load_done = 1'b1; load_done_reg = 5'd2;
        chk(1'b0, 1'b1);
        load_done_reg = 5'd3;
        push("load_count", 32'd3);
        chk(1'b0, 1'b1);
        load_done_reg = 5'd4;
        chk(1'b0, 1'b1);
        load_done_reg = 5'd8;
        push("load_count", 32'd1);
        chk(1'b0, 1'b1);
        load_done = 1'b0;
        push("load_count", 32'd0);
        push("pending", 32'd0);
        chk(1'b1, 1'b0);

        // nop with a raw hazard never stalls
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd9;
        chk(1'b1, 1'b0);
        idle(); dec_valid = 1'b1; dec_is_nop = 1'b1;
        dec_reg_read_1 = 5'd9; dec_reg_write = 5'd9;
        push("pending", 32'h200);
        chk(1'b1, 1'b0);
        idle(); load_done = 1'b1; load_done_reg = 5'd9;
        chk(1'b0, 1'b0);
        idle();
        push("pending", 32'd0);
        push("load_count", 32'd0);
        chk(1'b0, 1'b0);

        // load to $0 counts without a scoreboard bit
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1;
        chk(1'b1, 1'b0);
        idle(); load_done = 1'b1;
        push("load_count", 32'd1);
        push("pending", 32'd0);
        chk(1'b0, 1'b0);
        idle();
        push("load_count", 32'd0);
        chk(1'b0, 1'b0);

        // waw stall, then flush squashes without counting a stall cycle
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd7;
        chk(1'b1, 1'b0);
        chk(1'b0, 1'b1);
        flush = 1'b1;
        push("stall_cycles", sc_exp);
        chk(1'b0, 1'b0);
        idle();
        push("stall_cycles", sc_exp);
        push("pending", 32'h80);
        chk(1'b0, 1'b0);

        // async reset mid-countdown with two loads pending
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd10;
        chk(1'b1, 1'b0);
        idle(); dec_valid = 1'b1; dec_is_mulexec = 1'b1;
        chk(1'b1, 1'b0);
        idle(); dec_valid = 1'b1; dec_reg_read_2 = 5'd10;
        push("mul_busy", 32'd1);
        push("load_count", 32'd2);
        push("pending", 32'h480);
        chk(1'b0, 1'b1);
        rst = 1'b1;
        #2;
        push("issue", 32'd0);
        push("stall", 32'd0);
        push("pending", 32'd0);
        push("load_count", 32'd0);
        push("mul_busy", 32'd0);
        push("stall_cycles", 32'd0);
        drain_check();
        sc_exp = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(); load_done = 1'b1; load_done_reg = 5'd7;
        chk(1'b0, 1'b0);
        idle();
        push("load_count", 32'd0);
        push("pending", 32'd0);
        chk(1'b0, 1'b0);

        // stall counter saturation from a preloaded value
        idle(); dec_valid = 1'b1; dec_is_load = 1'b1; dec_reg_write = 5'd11;
        chk(1'b1, 1'b0);
        dut.stall_cycles_q = 32'hFFFF_FFFE;
        idle(); dec_valid = 1'b1; dec_reg_read_1 = 5'd11;
        push("stall_cycles", 32'hFFFF_FFFE);
        chk(1'b0, 1'b1);
        push("stall_cycles", 32'hFFFF_FFFF);
        chk(1'b0, 1'b1);
        push("stall_cycles", 32'hFFFF_FFFF);
        chk(1'b0, 1'b1);
        idle();
        push("stall_cycles", 32'hFFFF_FFFF);
        chk(1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
